// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg
// Shared constants and types for the MM.SS seven-segment display driver.
// Revision: 1.0
// ============================================================================
package seg_pkg;

  // Active-low segment patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit position: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens
  typedef logic [1:0] digit_idx_t;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  // BCD digit to segment pattern; non-decimal codes render blank
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    code = SEG_BLANK;
    if (digit <= 4'd9) code = SEG_DIGIT[digit];
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_driver_bin_to_bcd6.sv
`default_nettype none
// ============================================================================
// bin_to_bcd6
// Combinational 6-bit binary to two-digit BCD; ovf flags values above 59.
// Revision: 1.0
// ============================================================================
module bin_to_bcd6 (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);

  logic [5:0] rem;

  // Threshold cascade: the range is small enough that a divider is overkill
  always_comb begin
    ovf  = (bin > 6'd59);
    tens = 4'd0;
    rem  = bin;
    if (bin >= 6'd60) begin
      tens = 4'd6;
      rem  = bin - 6'd60;
    end else if (bin >= 6'd50) begin
      tens = 4'd5;
      rem  = bin - 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      rem  = bin - 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      rem  = bin - 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      rem  = bin - 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      rem  = bin - 6'd10;
    end
    ones = rem[3:0];
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// seg_display_driver
// 4-digit multiplexed active-low MM.SS display with adjust-field blinking.
// Revision: 1.0
// ============================================================================
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       blink,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int REFRESH_W = $clog2(REFRESH_DIV);
  localparam int BLINK_W   = $clog2(BLINK_DIV);
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);

  logic [REFRESH_W-1:0] refresh_cnt;
  logic                 tick;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;

  state_t     state, state_next;
  digit_idx_t idx, idx_next;
  logic       capture;

  logic [5:0] snap_min, snap_sec;
  logic       snap_blink, snap_sel;

  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       min_ovf, sec_ovf;
  logic [6:0] digit_code;

  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign tick = (refresh_cnt == REFRESH_LAST);

  // Free-running digit dwell counter
  always_ff @(posedge clk) begin
    if (!reset_n || tick) refresh_cnt <= '0;
    else                  refresh_cnt <= refresh_cnt + REFRESH_W'(1);
  end

  // Blink half-period timer; parked in the visible phase while not adjusting
  always_ff @(posedge clk) begin
    if (!reset_n || !blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  // Frame snapshot: inputs are only sampled at frame boundaries
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snap_min   <= '0;
      snap_sec   <= '0;
      snap_blink <= 1'b0;
      snap_sel   <= 1'b0;
    end else if (capture) begin
      snap_min   <= min;
      snap_sec   <= sec;
      snap_blink <= blink;
      snap_sel   <= sel;
    end
  end

  bin_to_bcd6 u_min_bcd (
    .bin  (snap_min),
    .tens (min_tens),
    .ones (min_ones),
    .ovf  (min_ovf)
  );

  bin_to_bcd6 u_sec_bcd (
    .bin  (snap_sec),
    .tens (sec_tens),
    .ones (sec_ones),
    .ovf  (sec_ovf)
  );

  // Pick the segment pattern for the digit currently being scanned
  always_comb begin
    digit_code = SEG_BLANK;
    case (idx)
      2'd0: digit_code = sec_ovf ? SEG_DASH : seg_encode(sec_ones);
      2'd1: digit_code = sec_ovf ? SEG_DASH : seg_encode(sec_tens);
      2'd2: digit_code = min_ovf ? SEG_DASH : seg_encode(min_ones);
      2'd3: digit_code = min_ovf ? SEG_DASH : seg_encode(min_tens);
      default: digit_code = SEG_BLANK;
    endcase
  end

  // Scan FSM: next state, digit index, snapshot strobe and next outputs
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    an_next    = 4'b1111;
    seg_next   = SEG_BLANK;
    dp_next    = 1'b1;
    case (state)
      BLANK: begin
        if (tick) begin
          state_next = SCAN;
          idx_next   = '0;
          capture    = 1'b1;
        end
      end
      SCAN: begin
        if (tick) begin
          idx_next = idx + 2'd1;
          capture  = (idx == 2'd3);
        end
        an_next  = ~(4'b0001 << idx);
        seg_next = digit_code;
        dp_next  = (idx != 2'd2);
        // Only the anodes are suppressed so the separator keeps its timing
        if (snap_blink && blink_phase) begin
          if (snap_sel) an_next[1:0] = 2'b11;
          else          an_next[3:2] = 2'b11;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // State, index and registered display outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BLANK;
      idx   <= '0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      an    <= an_next;
      seg   <= seg_next;
      dp    <= dp_next;
    end
  end

endmodule
`default_nettype wire
